// File: rtl/alu_result_checker_pkg.sv
// Shared ALUOp encodings, checker FSM states and compare-mask helpers.
package alu_result_checker_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_PASS = 3'b000;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b011;
  localparam logic [OP_W-1:0] OP_OR   = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

  // The reference model only produces a meaningful result for these ops.
  function automatic logic op_defined(input logic [OP_W-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_PASS, OP_NOT, OP_AND, OP_OR, OP_SUB, OP_ADD: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Only arithmetic ops produce a carry worth comparing.
  function automatic logic op_has_carry(input logic [OP_W-1:0] op);
    return (op == OP_SUB) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/alu_cmp_stage.sv
// Stage-1 beat register plus the op-masked DUT-vs-model comparator.
module alu_cmp_stage
  import alu_result_checker_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic [OP_W-1:0] alu_op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    result_dut,
  input  logic            c_out_dut,
  input  logic [W-1:0]    result_v,
  input  logic            c_out_v,
  output logic            beat_valid,
  output logic            beat_err,
  output logic [OP_W-1:0] beat_op,
  output logic [W-1:0]    beat_a,
  output logic [W-1:0]    beat_b,
  output logic [W-1:0]    beat_dut,
  output logic [W-1:0]    beat_ref
);

  logic c_dut_q;
  logic c_ref_q;

  // Capture an accepted beat; data holds through gaps, valid marks fresh beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_valid <= 1'b0;
      beat_op    <= '0;
      beat_a     <= '0;
      beat_b     <= '0;
      beat_dut   <= '0;
      beat_ref   <= '0;
      c_dut_q    <= 1'b0;
      c_ref_q    <= 1'b0;
    end else if (clear) begin
      beat_valid <= 1'b0;
      beat_op    <= '0;
      beat_a     <= '0;
      beat_b     <= '0;
      beat_dut   <= '0;
      beat_ref   <= '0;
      c_dut_q    <= 1'b0;
      c_ref_q    <= 1'b0;
    end else begin
      beat_valid <= load;
      if (load) begin
        beat_op  <= alu_op;
        beat_a   <= a;
        beat_b   <= b;
        beat_dut <= result_dut;
        beat_ref <= result_v;
        c_dut_q  <= c_out_dut;
        c_ref_q  <= c_out_v;
      end
    end
  end

  // Mismatch under the op mask: undefined ops never fail, carry only for add/sub.
  always_comb begin
    beat_err = 1'b0;
    if (beat_valid && op_defined(beat_op)) begin
      beat_err = (beat_dut != beat_ref) ||
                 (op_has_carry(beat_op) && (c_dut_q != c_ref_q));
    end
  end

endmodule

// File: rtl/alu_result_checker.sv
// Run-framed scoreboard: start/done FSM, pass/fail counters, first-error capture.
module alu_result_checker
  import alu_result_checker_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     result_dut,
  input  logic             c_out_dut,
  input  logic [W-1:0]     result_v,
  input  logic             c_out_v,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [OP_W-1:0]  first_err_op,
  output logic [W-1:0]     first_err_a,
  output logic [W-1:0]     first_err_b,
  output logic [W-1:0]     first_err_dut,
  output logic [W-1:0]     first_err_ref
);

  chk_state_t       state;
  logic [CNT_W-1:0] num_vec_q;
  logic [CNT_W-1:0] accept_cnt;

  logic             accept;
  logic             start_ok;
  logic             beat_valid;
  logic             beat_err;
  logic [OP_W-1:0]  beat_op;
  logic [W-1:0]     beat_a;
  logic [W-1:0]     beat_b;
  logic [W-1:0]     beat_dut;
  logic [W-1:0]     beat_ref;

  logic             vec_inc;
  logic             err_inc;
  logic [CNT_W-1:0] err_cnt_nxt;

  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

  alu_cmp_stage #(.W(W)) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .load       (accept),
    .alu_op     (alu_op),
    .a          (a),
    .b          (b),
    .result_dut (result_dut),
    .c_out_dut  (c_out_dut),
    .result_v   (result_v),
    .c_out_v    (c_out_v),
    .beat_valid (beat_valid),
    .beat_err   (beat_err),
    .beat_op    (beat_op),
    .beat_a     (beat_a),
    .beat_b     (beat_b),
    .beat_dut   (beat_dut),
    .beat_ref   (beat_ref)
  );

  // Stage-2 bookkeeping: vec_cnt capped at num_vec, err_cnt saturating.
  always_comb begin
    vec_inc     = 1'b0;
    err_inc     = 1'b0;
    err_cnt_nxt = err_cnt;
    if (beat_valid && (vec_cnt < num_vec_q)) begin
      vec_inc = 1'b1;
      err_inc = beat_err;
    end
    if (err_inc && (err_cnt != '1)) begin
      err_cnt_nxt = err_cnt + CNT_W'(1);
    end
  end

  // Run FSM with registered status outputs and stage-2 counter/capture updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      num_vec_q     <= '0;
      accept_cnt    <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_pulse     <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_op  <= '0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_dut <= '0;
      first_err_ref <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (start_ok) begin
        num_vec_q     <= num_vec;
        accept_cnt    <= '0;
        vec_cnt       <= '0;
        err_cnt       <= '0;
        first_err_idx <= '0;
        first_err_op  <= '0;
        first_err_a   <= '0;
        first_err_b   <= '0;
        first_err_dut <= '0;
        first_err_ref <= '0;
        if (num_vec != '0) begin
          state    <= ST_RUN;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
          pass     <= 1'b0;
        end else begin
          state    <= ST_DONE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          pass     <= 1'b1;
        end
      end else begin
        if (vec_inc) begin
          vec_cnt   <= vec_cnt + CNT_W'(1);
          err_cnt   <= err_cnt_nxt;
          err_pulse <= err_inc;
          if (err_inc && (err_cnt == '0)) begin
            first_err_idx <= vec_cnt;
            first_err_op  <= beat_op;
            first_err_a   <= beat_a;
            first_err_b   <= beat_b;
            first_err_dut <= beat_dut;
            first_err_ref <= beat_ref;
          end
        end
        case (state)
          ST_RUN: begin
            if (accept) begin
              accept_cnt <= accept_cnt + CNT_W'(1);
              if ((accept_cnt + CNT_W'(1)) == num_vec_q) begin
                state    <= ST_DRAIN;
                in_ready <= 1'b0;
              end
            end
          end
          ST_DRAIN: begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt_nxt == '0);
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Self-checking bench: directed vector table, corner sequences, randomized runs vs a counting model.
module tb_alu_result_checker;

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 16;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    logic        cd;
    logic [31:0] rv;
    logic        cv;
  } beat_t;

  typedef struct {
    beat_t bt;
    logic  exp_err;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     result_dut;
  logic             c_out_dut;
  logic [W-1:0]     result_v;
  logic             c_out_v;
  logic             busy;
  logic             done;
  logic             pass;
  logic             err_pulse;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_err_idx;
  logic [2:0]       first_err_op;
  logic [W-1:0]     first_err_a;
  logic [W-1:0]     first_err_b;
  logic [W-1:0]     first_err_dut;
  logic [W-1:0]     first_err_ref;

  int n_tests = 0;
  int n_fail  = 0;

  alu_result_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_vec       (num_vec),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_op        (alu_op),
    .a             (a),
    .b             (b),
    .result_dut    (result_dut),
    .c_out_dut     (c_out_dut),
    .result_v      (result_v),
    .c_out_v       (c_out_v),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_pulse     (err_pulse),
    .vec_cnt       (vec_cnt),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx),
    .first_err_op  (first_err_op),
    .first_err_a   (first_err_a),
    .first_err_b   (first_err_b),
    .first_err_dut (first_err_dut),
    .first_err_ref (first_err_ref)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Spec compare rule, stated per op.
  function automatic logic beat_bad(input beat_t bt);
    case (bt.op)
      3'b000, 3'b001, 3'b011, 3'b100: return bt.rd != bt.rv;
      3'b101, 3'b110:                 return (bt.rd != bt.rv) || (bt.cd != bt.cv);
      default:                        return 1'b0;
    endcase
  endfunction

  // Clean beat where the DUT ALU agrees with a plain arithmetic reference.
  function automatic beat_t clean_beat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    beat_t bt;
    logic [32:0] s;
    bt.op = op; bt.a = x; bt.b = y; bt.cv = 1'b0; bt.rv = 32'd0;
    case (op)
      3'b000: bt.rv = x;
      3'b001: bt.rv = ~x;
      3'b011: bt.rv = x & y;
      3'b100: bt.rv = x | y;
      3'b101: begin s = {1'b0, x} + {1'b0, ~y} + 33'd1; bt.rv = s[31:0]; bt.cv = s[32]; end
      3'b110: begin s = {1'b0, x} + {1'b0, y}; bt.rv = s[31:0]; bt.cv = s[32]; end
      default: begin bt.rv = $urandom; bt.cv = 1'($urandom_range(0, 1)); end
    endcase
    bt.rd = bt.rv;
    bt.cd = bt.cv;
    if (op == 3'b010 || op == 3'b111) begin
      bt.rd = $urandom;
      bt.cd = 1'($urandom_range(0, 1));
    end
    return bt;
  endfunction

  function automatic beat_t rand_beat();
    beat_t bt;
    bt = clean_beat(3'($urandom_range(0, 7)), $urandom, $urandom);
    if ($urandom_range(0, 3) == 0) bt.rd = bt.rv ^ (32'd1 << $urandom_range(0, 31));
    if ($urandom_range(0, 5) == 0) bt.cd = ~bt.cv;
    return bt;
  endfunction

  // ---------------- cycle-level reference model ----------------
  int    m_vec, m_err, m_acc, m_n;
  logic  m_started, m_pulse, m_s1v;
  beat_t m_s1;
  int    m_fidx;
  beat_t m_fbt;
  logic  d_start, d_acc;
  int    d_n;
  beat_t d_beat;
  logic  m_busy, e_ready, e_done, e_pass;

  initial begin
    d_start = 1'b0; d_acc = 1'b0; d_n = 0; m_s1v = 1'b0; m_started = 1'b0;
  end

  // Samples mid-low-phase: applies the effects of the edge just passed, then
  // compares every output and records what the next edge will do.
  always @(negedge clk) begin
    #2;
    m_pulse = 1'b0;
    if (!rst_n) begin
      m_vec = 0; m_err = 0; m_acc = 0; m_n = 0; m_started = 1'b0; m_s1v = 1'b0;
      m_fidx = 0; m_fbt = '{default: '0};
    end else if (d_start) begin
      m_started = 1'b1; m_n = d_n; m_acc = 0; m_vec = 0; m_err = 0; m_s1v = 1'b0;
      m_fidx = 0; m_fbt = '{default: '0};
    end else begin
      if (m_s1v) begin
        if (beat_bad(m_s1)) begin
          if (m_err == 0) begin m_fidx = m_vec; m_fbt = m_s1; end
          if (m_err < 65535) m_err++;
          m_pulse = 1'b1;
        end
        m_vec++;
      end
      m_s1v = d_acc;
      if (d_acc) begin m_s1 = d_beat; m_acc++; end
    end
    m_busy  = m_started && (m_vec < m_n);
    e_ready = m_busy && (m_acc < m_n);
    e_done  = m_started && !m_busy;
    e_pass  = e_done && (m_err == 0);
    check("in_ready", 64'(in_ready), 64'(e_ready));
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(e_done));
    check("pass", 64'(pass), 64'(e_pass));
    check("err_pulse", 64'(err_pulse), 64'(m_pulse));
    check("vec_cnt", 64'(vec_cnt), 64'(m_vec));
    check("err_cnt", 64'(err_cnt), 64'(m_err));
    check("first_err_idx", 64'(first_err_idx), 64'(m_fidx));
    check("first_err_op", 64'(first_err_op), 64'(m_fbt.op));
    check("first_err_a", 64'(first_err_a), 64'(m_fbt.a));
    check("first_err_b", 64'(first_err_b), 64'(m_fbt.b));
    check("first_err_dut", 64'(first_err_dut), 64'(m_fbt.rd));
    check("first_err_ref", 64'(first_err_ref), 64'(m_fbt.rv));
    d_start = rst_n && start && !m_busy;
    d_n     = int'(num_vec);
    d_acc   = rst_n && in_valid && e_ready;
    d_beat  = '{op: alu_op, a: a, b: b, rd: result_dut, cd: c_out_dut, rv: result_v, cv: c_out_v};
  end

  // ---------------- drivers (entered and left on a falling edge) ----------------
  task automatic start_run(input int n);
    start = 1'b1;
    num_vec = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input beat_t bt, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin in_valid = 1'b0; @(negedge clk); end
    alu_op = bt.op; a = bt.a; b = bt.b;
    result_dut = bt.rd; c_out_dut = bt.cd; result_v = bt.rv; c_out_v = bt.cv;
    in_valid = 1'b1;
    t = 0;
    #1;
    while (!in_ready && t < 100) begin @(negedge clk); #1; t++; end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 200) begin @(negedge clk); t++; end
    check({name, "_done"}, 64'(done), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];
  int   exp_errs;
  int   first_i;
  int   n;
  int   bad;
  beat_t bt0, bt2;

  initial begin
    tbl[0] = '{bt: '{op: 3'b110, a: 32'hFFFFFFFF, b: 32'h1, rd: 32'h0, cd: 1'b1, rv: 32'h0, cv: 1'b1}, exp_err: 1'b0};
    tbl[1] = '{bt: '{op: 3'b110, a: 32'hFFFFFFFF, b: 32'h1, rd: 32'h0, cd: 1'b0, rv: 32'h0, cv: 1'b1}, exp_err: 1'b1};
    tbl[2] = '{bt: '{op: 3'b011, a: 32'hF0F0, b: 32'hFF00, rd: 32'hF000, cd: 1'b1, rv: 32'hF000, cv: 1'b0}, exp_err: 1'b0};
    tbl[3] = '{bt: '{op: 3'b111, a: 32'h1, b: 32'h2, rd: 32'h1234, cd: 1'b1, rv: 32'h5678, cv: 1'b0}, exp_err: 1'b0};
    tbl[4] = '{bt: '{op: 3'b010, a: 32'h3, b: 32'h4, rd: 32'hAAAA, cd: 1'b0, rv: 32'h5555, cv: 1'b1}, exp_err: 1'b0};
    tbl[5] = '{bt: '{op: 3'b101, a: 32'h5, b: 32'h7, rd: 32'hFFFFFFFE, cd: 1'b0, rv: 32'hFFFFFFFE, cv: 1'b1}, exp_err: 1'b1};
    tbl[6] = '{bt: '{op: 3'b001, a: 32'h0, b: 32'h9, rd: 32'hFFFFFFFF, cd: 1'b0, rv: 32'hFFFFFFFF, cv: 1'b0}, exp_err: 1'b0};
    tbl[7] = '{bt: '{op: 3'b100, a: 32'h1, b: 32'h2, rd: 32'h3, cd: 1'b0, rv: 32'h7, cv: 1'b0}, exp_err: 1'b1};
    tbl[8] = '{bt: '{op: 3'b000, a: 32'hDEAD, b: 32'h0, rd: 32'hDEAD, cd: 1'b1, rv: 32'hDEAD, cv: 1'b0}, exp_err: 1'b0};
    tbl[9] = '{bt: '{op: 3'b101, a: 32'h9, b: 32'h2, rd: 32'h7, cd: 1'b1, rv: 32'h7, cv: 1'b1}, exp_err: 1'b0};

    rst_n = 1'b0; start = 1'b0; num_vec = '0; in_valid = 1'b0;
    alu_op = '0; a = '0; b = '0; result_dut = '0; c_out_dut = 1'b0; result_v = '0; c_out_v = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(0));
    check("reset_vec_cnt", 64'(vec_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, one beat at a time, err_pulse checked per beat.
    start_run(10);
    #3;
    check("tbl_busy_after_start", 64'(busy), 64'(1));
    check("tbl_vec_after_start", 64'(vec_cnt), 64'(0));
    @(negedge clk);
    exp_errs = 0; first_i = -1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].bt, 0);
      in_valid = 1'b0;
      @(negedge clk);
      #3;
      check($sformatf("tbl%0d_err_pulse", i), 64'(err_pulse), 64'(tbl[i].exp_err));
      if (tbl[i].exp_err) begin
        if (first_i < 0) first_i = i;
        exp_errs++;
      end
      @(negedge clk);
    end
    wait_done("tbl");
    check("tbl_err_cnt", 64'(err_cnt), 64'(exp_errs));
    check("tbl_first_idx", 64'(first_err_idx), 64'(first_i));
    check("tbl_first_op", 64'(first_err_op), 64'(3'b110));
    check("tbl_first_a", 64'(first_err_a), 64'(32'hFFFFFFFF));
    check("tbl_pass", 64'(pass), 64'(0));

    // Four matching beats back-to-back: done two cycles after the last accept.
    start_run(4);
    send(clean_beat(3'b110, 32'h10, 32'h20), 0);
    send(clean_beat(3'b101, 32'h30, 32'h50), 0);
    send(clean_beat(3'b011, 32'hFF, 32'h0F), 0);
    send(clean_beat(3'b100, 32'hF0, 32'h0F), 0);
    in_valid = 1'b0;
    #3;
    check("b2b_ready_after_last", 64'(in_ready), 64'(0));
    check("b2b_done_early", 64'(done), 64'(0));
    @(negedge clk);
    #3;
    check("b2b_done", 64'(done), 64'(1));
    check("b2b_pass", 64'(pass), 64'(1));
    check("b2b_vec_cnt", 64'(vec_cnt), 64'(4));
    check("b2b_err_cnt", 64'(err_cnt), 64'(0));
    @(negedge clk);

    // Failures at beats 0 and 2 with in_valid toggling.
    bt0 = clean_beat(3'b000, 32'hAAAA0001, 32'h0); bt0.rd = 32'h1;
    bt2 = clean_beat(3'b110, 32'h5, 32'h6);        bt2.rd = 32'h0;
    start_run(5);
    send(bt0, 1);
    send(clean_beat(3'b001, 32'h77, 32'h0), 1);
    send(bt2, 1);
    send(clean_beat(3'b011, 32'h1, 32'h3), 1);
    send(clean_beat(3'b100, 32'h8, 32'h3), 1);
    in_valid = 1'b0;
    wait_done("two_err");
    check("two_err_vec", 64'(vec_cnt), 64'(5));
    check("two_err_cnt", 64'(err_cnt), 64'(2));
    check("two_err_idx", 64'(first_err_idx), 64'(0));
    check("two_err_a", 64'(first_err_a), 64'(32'hAAAA0001));
    check("two_err_dut", 64'(first_err_dut), 64'(32'h1));
    check("two_err_ref", 64'(first_err_ref), 64'(32'hAAAA0001));

    // Reset mid-run, then a clean run of four.
    start_run(6);
    for (int i = 0; i < 3; i++) send(clean_beat(3'b110, $urandom, $urandom), 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_vec", 64'(vec_cnt), 64'(0));
    check("midrst_ready", 64'(in_ready), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(4);
    for (int i = 0; i < 4; i++) send(clean_beat(3'b101, $urandom, $urandom), 0);
    in_valid = 1'b0;
    wait_done("postrst");
    check("postrst_pass", 64'(pass), 64'(1));
    check("postrst_vec", 64'(vec_cnt), 64'(4));

    // Zero-length run.
    start_run(0);
    #3;
    check("zero_done", 64'(done), 64'(1));
    check("zero_pass", 64'(pass), 64'(1));
    check("zero_busy", 64'(busy), 64'(0));
    @(negedge clk);

    // start during RUN is ignored.
    start_run(3);
    send(clean_beat(3'b000, 32'h1, 32'h2), 0);
    in_valid = 1'b0;
    start_run(9);
    #3;
    check("ign_start_vec", 64'(vec_cnt), 64'(1));
    check("ign_start_busy", 64'(busy), 64'(1));
    @(negedge clk);
    send(clean_beat(3'b011, 32'h3, 32'h2), 0);
    send(clean_beat(3'b100, 32'h3, 32'h4), 0);
    in_valid = 1'b0;
    wait_done("ign");
    check("ign_vec", 64'(vec_cnt), 64'(3));

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 40);
      bad = 0;
      start_run(n);
      for (int i = 0; i < n; i++) begin
        beat_t bt;
        bt = rand_beat();
        if (beat_bad(bt)) bad++;
        send(bt, $urandom_range(0, 2));
      end
      in_valid = 1'b0;
      wait_done($sformatf("rand%0d", r));
      check($sformatf("rand%0d_vec", r), 64'(vec_cnt), 64'(n));
      check($sformatf("rand%0d_err", r), 64'(err_cnt), 64'(bad));
      check($sformatf("rand%0d_pass", r), 64'(pass), 64'(bad == 0));
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
